// File: rtl/magic_glove_pkg.sv
// Shared types and constants for the gesture top-3 selection path.
// The score/index slot layout is common to the selector and its insertion logic.
package magic_glove_pkg;

  localparam int N_CLASS = 27;
  localparam int IDX_W   = 5;
  localparam int SCORE_W = 16;

  typedef logic [IDX_W-1:0]          class_idx_t;
  typedef logic signed [SCORE_W-1:0] score_t;

  typedef struct packed {
    score_t     score;
    class_idx_t idx;
  } top_slot_t;

  typedef top_slot_t [0:2] top3_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam score_t     SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam class_idx_t LAST_IDX  = class_idx_t'(N_CLASS - 1);

  // Empty slots hold the most-negative score, so any real score displaces them.
  function automatic top3_t top3_init();
    top3_t t;
    for (int k = 0; k < 3; k++) begin
      t[k].score = SCORE_MIN;
      t[k].idx   = '0;
    end
    return t;
  endfunction

endpackage

// File: rtl/top3_select_if.sv
// Stream-in / winners-out bundle between the classifier, top3_select and dedup.
interface top3_select_if;
  import magic_glove_pkg::*;

  logic             i_start;
  logic             i_valid;
  score_t           i_score;
  logic             o_ready;
  class_idx_t [0:2] o_tops;
  class_idx_t [0:2] o_prev_tops;
  logic             o_prev_valid;
  logic             o_next;
  logic             o_busy;

  modport slave (
    input  i_start, i_valid, i_score,
    output o_ready, o_tops, o_prev_tops, o_prev_valid, o_next, o_busy
  );

  modport master (
    output i_start, i_valid, i_score,
    input  o_ready, o_tops, o_prev_tops, o_prev_valid, o_next, o_busy
  );

endinterface

// File: rtl/top3_insert.sv
// Combinational insertion of one (score, index) into a sorted top-3 list.
// Strict greater-than keeps the earlier index on ties.
module top3_insert
  import magic_glove_pkg::*;
(
  input  top3_t      top_in,
  input  score_t     score,
  input  class_idx_t idx,
  output top3_t      top_out
);

  top_slot_t new_slot;

  always_comb begin
    new_slot.score = score;
    new_slot.idx   = idx;
    top_out        = top_in;
    if (score > top_in[0].score) begin
      top_out[2] = top_in[1];
      top_out[1] = top_in[0];
      top_out[0] = new_slot;
    end else if (score > top_in[1].score) begin
      top_out[2] = top_in[1];
      top_out[1] = new_slot;
    end else if (score > top_in[2].score) begin
      top_out[2] = new_slot;
    end
  end

endmodule

// File: rtl/top3_select.sv
// Per-frame running top-3 of classifier scores; publishes winners plus the
// previous frame's winners and pulses o_next for the dedup stage.
//
//   state  | meaning
//   S_IDLE | slots/counter held at initial values, waiting for i_start
//   S_SCAN | accepting one score per i_valid, index = cnt
//   S_OUT  | one cycle; winners and history registered on exit edge
module top3_select
  import magic_glove_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  top3_select_if.slave  bus
);

  state_t           state, state_d;
  class_idx_t       cnt, cnt_d;
  top3_t            slots, slots_d, slots_ins;
  class_idx_t [0:2] tops_q, prev_tops_q;
  logic             prev_valid_q, next_q, done_once_q;

  top3_insert u_insert (
    .top_in  (slots),
    .score   (bus.i_score),
    .idx     (cnt),
    .top_out (slots_ins)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      slots <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      slots <= slots_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    slots_d = slots;
    case (state)
      S_IDLE: begin
        cnt_d   = '0;
        slots_d = top3_init();
        if (bus.i_start) state_d = S_SCAN;
      end
      S_SCAN: begin
        // A restart wins over a score presented in the same cycle.
        if (bus.i_start) begin
          cnt_d   = '0;
          slots_d = top3_init();
        end else if (bus.i_valid) begin
          slots_d = slots_ins;
          cnt_d   = cnt + 1'b1;
          if (cnt == LAST_IDX) state_d = S_OUT;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tops_q       <= '0;
      prev_tops_q  <= '0;
      prev_valid_q <= 1'b0;
      next_q       <= 1'b0;
      done_once_q  <= 1'b0;
    end else begin
      next_q <= (state == S_OUT);
      if (state == S_OUT) begin
        prev_tops_q  <= tops_q;
        for (int k = 0; k < 3; k++) tops_q[k] <= slots[k].idx;
        prev_valid_q <= done_once_q;
        done_once_q  <= 1'b1;
      end
    end
  end

  assign bus.o_ready      = (state == S_SCAN);
  assign bus.o_busy       = (state != S_IDLE);
  assign bus.o_tops       = tops_q;
  assign bus.o_prev_tops  = prev_tops_q;
  assign bus.o_prev_valid = prev_valid_q;
  assign bus.o_next       = next_q;

endmodule

// File: tb/tb_top3_select.sv
// Bench for top3_select: table-driven frames, stalls, restart, async reset,
// and random frames against a sort-based top-3 model.
module tb_top3_select;
  import magic_glove_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  top3_select_if bus_if ();

  top3_select dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus_if)
  );

  typedef struct {
    bit ramp;
    int base;
    int i0, v0, i1, v1, i2, v2;
    int e0, e1, e2;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame [N_CLASS];
  int   exp_t [3];
  int   hist  [3];
  int   frames_done = 0;
  vec_t vecs  [4];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: repeatedly pick the highest remaining score, lowest index on ties.
  function automatic void ref_top3();
    bit used [N_CLASS];
    int best;
    for (int i = 0; i < N_CLASS; i++) used[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      best = -1;
      for (int i = 0; i < N_CLASS; i++)
        if (!used[i] && (best < 0 || frame[i] > frame[best])) best = i;
      used[best] = 1'b1;
      exp_t[k] = best;
    end
  endfunction

  function automatic void fill_frame(input vec_t v);
    for (int i = 0; i < N_CLASS; i++) frame[i] = v.ramp ? i : v.base;
    if (!v.ramp) begin
      frame[v.i0] = v.v0;
      frame[v.i1] = v.v1;
      frame[v.i2] = v.v2;
    end
  endfunction

  task automatic check_zero_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_tops"}, int'(bus_if.o_tops[k]), 0);
      chk({tag, "_prev_tops"}, int'(bus_if.o_prev_tops[k]), 0);
    end
    chk({tag, "_prev_valid"}, int'(bus_if.o_prev_valid), 0);
    chk({tag, "_next"}, int'(bus_if.o_next), 0);
    chk({tag, "_ready"}, int'(bus_if.o_ready), 0);
    chk({tag, "_busy"}, int'(bus_if.o_busy), 0);
  endtask

  task automatic pulse_start();
    bus_if.i_start = 1'b1;
    bus_if.i_valid = 1'b0;
    @(posedge i_clk); #1;
    bus_if.i_start = 1'b0;
  endtask

  task automatic partial(input int n);
    pulse_start();
    for (int i = 0; i < n; i++) begin
      bus_if.i_valid = 1'b1;
      bus_if.i_score = score_t'($urandom_range(0, 65535));
      @(posedge i_clk); #1;
    end
    bus_if.i_valid = 1'b0;
  endtask

  task automatic run_frame(input bit stall, input bit start_in_out,
                           input int e0, input int e1, input int e2);
    int nst;
    pulse_start();
    chk("scan_busy", int'(bus_if.o_busy), 1);
    chk("scan_ready", int'(bus_if.o_ready), 1);
    for (int i = 0; i < N_CLASS; i++) begin
      if (stall && $urandom_range(0, 3) == 0) begin
        nst = int'($urandom_range(1, 4));
        bus_if.i_valid = 1'b0;
        bus_if.i_score = score_t'($urandom_range(0, 65535));
        repeat (nst) begin
          @(posedge i_clk); #1;
          chk("stall_ready", int'(bus_if.o_ready), 1);
        end
      end
      bus_if.i_valid = 1'b1;
      bus_if.i_score = score_t'(frame[i]);
      @(posedge i_clk); #1;
    end
    bus_if.i_valid = 1'b0;
    chk("next_early", int'(bus_if.o_next), 0);
    chk("out_busy", int'(bus_if.o_busy), 1);
    bus_if.i_start = start_in_out;
    @(posedge i_clk); #1;
    bus_if.i_start = 1'b0;
    chk("next_pulse", int'(bus_if.o_next), 1);
    chk("top0", int'(bus_if.o_tops[0]), e0);
    chk("top1", int'(bus_if.o_tops[1]), e1);
    chk("top2", int'(bus_if.o_tops[2]), e2);
    for (int k = 0; k < 3; k++)
      chk("prev_tops", int'(bus_if.o_prev_tops[k]), hist[k]);
    chk("prev_valid", int'(bus_if.o_prev_valid), (frames_done >= 1) ? 1 : 0);
    chk("idle_after_out", int'(bus_if.o_busy), 0);
    @(posedge i_clk); #1;
    chk("next_once", int'(bus_if.o_next), 0);
    chk("tops_hold", int'(bus_if.o_tops[0]), e0);
    hist[0] = e0; hist[1] = e1; hist[2] = e2;
    frames_done++;
  endtask

  initial begin
    vecs[0] = '{ramp: 1'b1, base: 0,    i0: 0,  v0: 0,   i1: 0, v1: 0,  i2: 0, v2: 0,
                e0: 26, e1: 25, e2: 24};
    vecs[1] = '{ramp: 1'b0, base: -5,   i0: 3,  v0: 100, i1: 7, v1: 90, i2: 12, v2: 80,
                e0: 3,  e1: 7,  e2: 12};
    vecs[2] = '{ramp: 1'b0, base: 16,   i0: 0,  v0: 16,  i1: 1, v1: 16, i2: 2, v2: 16,
                e0: 0,  e1: 1,  e2: 2};
    vecs[3] = '{ramp: 1'b0, base: -100, i0: 20, v0: -1,  i1: 5, v1: -2, i2: 9, v2: -3,
                e0: 20, e1: 5,  e2: 9};
    for (int k = 0; k < 3; k++) hist[k] = 0;

    bus_if.i_start = 1'b0;
    bus_if.i_valid = 1'b0;
    bus_if.i_score = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero_outputs("reset");
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Valid in IDLE must not start a frame.
    bus_if.i_valid = 1'b1;
    @(posedge i_clk); #1;
    chk("idle_ignores_valid", int'(bus_if.o_busy), 0);
    bus_if.i_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      fill_frame(vecs[v]);
      run_frame(1'b0, (v == 2), vecs[v].e0, vecs[v].e1, vecs[v].e2);
    end

    fill_frame(vecs[1]);
    run_frame(1'b1, 1'b0, 3, 7, 12);

    partial(10);
    fill_frame(vecs[0]);
    run_frame(1'b0, 1'b0, 26, 25, 24);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N_CLASS; i++)
        frame[i] = (r % 2 == 0) ? int'($urandom_range(0, 7)) - 4
                                : int'(score_t'($urandom_range(0, 65535)));
      ref_top3();
      run_frame(1'($urandom_range(0, 1)), 1'b0, exp_t[0], exp_t[1], exp_t[2]);
    end

    partial(8);
    #3;
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) hist[k] = 0;
    frames_done = 0;
    @(posedge i_clk); #1;
    fill_frame(vecs[0]);
    run_frame(1'b0, 1'b0, 26, 25, 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
